// File: rtl/bambu_mem_pkg.sv
// bambu_mem_pkg
// Shared definitions for the bambu memory initiator: default bus geometry,
// the default per-beat timeout, and the controller state encoding.
package bambu_mem_pkg;

  localparam int ADDR_W_DEF  = 14;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/bambu_beat_timer.sv
// bambu_beat_timer
// Per-beat watchdog. A down-counter that is reloaded by clear and counts down
// while enable is high; expired flags the terminal count.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high
//   clear   in   reload the counter (takes priority over enable)
//   enable  in   count down one step this cycle
//   expired out  counter has reached its terminal count
module bambu_beat_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // Loading TIMEOUT-1 makes expired assert in the TIMEOUT-th enabled cycle,
  // so the caller can leave on exactly that edge.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/bambu_mem_initiator.sv
// bambu_mem_initiator
// Burst memory initiator: runs read or write bursts of byte beats against a
// single-ported responder handshaked by M_DataRdy, with a per-beat timeout.
//
// state  | meaning
// IDLE   | waiting for start_port; all strobes low
// FETCH  | write burst: wr_ready high, waiting for the next source byte
// ACCESS | strobe (oe or we) high, waiting for M_DataRdy or timeout
// DONE   | one-cycle done_port pulse, then back to IDLE
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   start_port, op               burst launch pulse; 0 = read, 1 = write
//   base_addr, burst_len         first byte address, number of bytes
//   wr_data, wr_valid, wr_ready  write-byte source handshake
//   rd_data, rd_valid            read byte and its one-cycle valid pulse
//   done_port, error, busy       end-of-burst pulse, timeout flag, in-progress
//   Mout_*                       memory-side strobes, address, data, size
//   M_Rdata_ram, M_DataRdy       memory-side read data and beat completion
module bambu_mem_initiator
  import bambu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_port,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        burst_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done_port,
  output logic              error,
  output logic              busy,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [3:0]        Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  localparam logic [3:0] SIZE_BITS = 4'(DATA_W);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              error_q, error_d;
  logic              tmr_clear, tmr_expired, strobe;

  bambu_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (state_q == ACCESS),
    .expired (tmr_expired)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    error_d    = error_q;
    tmr_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_port) begin
          op_d    = op;
          addr_d  = base_addr;
          len_d   = burst_len;
          cnt_d   = '0;
          error_d = 1'b0;
          if (burst_len == 8'd0) begin
            state_d = DONE;
          end else if (op) begin
            state_d = FETCH;
          end else begin
            state_d   = ACCESS;
            tmr_clear = 1'b1;
          end
        end
      end
      FETCH: begin
        if (wr_valid) begin
          wdata_d   = wr_data;
          state_d   = ACCESS;
          tmr_clear = 1'b1;
        end
      end
      ACCESS: begin
        // A completing beat wins over a timeout landing in the same cycle.
        if (M_DataRdy) begin
          if (!op_q) begin
            rdata_d    = M_Rdata_ram;
            rd_valid_d = 1'b1;
          end
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end else if (op_q) begin
            state_d = FETCH;
          end else begin
            state_d   = ACCESS;
            tmr_clear = 1'b1;
          end
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
    end
  end

  assign strobe             = (state_q == ACCESS);
  assign Mout_oe_ram        = strobe & ~op_q;
  assign Mout_we_ram        = strobe & op_q;
  assign Mout_data_ram_size = strobe ? SIZE_BITS : 4'd0;
  assign Mout_addr_ram      = addr_q;
  assign Mout_Wdata_ram     = wdata_q;
  assign wr_ready           = (state_q == FETCH);
  assign busy               = (state_q == FETCH) || (state_q == ACCESS);
  assign done_port          = (state_q == DONE);
  assign error              = error_q;
  assign rd_data            = rdata_q;
  assign rd_valid           = rd_valid_q;

endmodule
